// File: rtl/pe_seq_pkg.sv
// Shared defaults, derived widths and state encodings for the PE convolution sequencer.
package pe_seq_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_K      = 5;
    localparam int DEF_DIM    = 8;
    localparam int DEF_PE_LAT = 6;
    localparam int DEF_GAP    = 20;

    localparam int CW  = $clog2(DEF_DIM);
    localparam int WCW = $clog2(DEF_K * DEF_K + 1);
    localparam int PCW = $clog2(DEF_DIM * DEF_DIM + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD_W = ST_LOAD_W,
        S_GAP    = ST_GAP,
        S_STREAM = ST_STREAM,
        S_DRAIN  = ST_DRAIN,
        S_DONE   = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/pe_seq_delay.sv
// Fixed-depth shift register carrying the {tag,row,col} window tag alongside the PE pipeline.
module pe_seq_delay #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per cycle, no enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/pe_conv_sequencer.sv
// Drives one convolution job through the PE: weight load, gap, pixel stream, drain.
// Optional macro SEQ_STALL_CNT_EN adds a saturating bubble counter output stall_cnt.
module pe_conv_sequencer
    import pe_seq_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int K      = DEF_K,
    parameter int DIM    = DEF_DIM,
    parameter int PE_LAT = DEF_PE_LAT,
    parameter int GAP    = DEF_GAP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    wt_valid,
    output logic                    wt_ready,
    input  logic [W-1:0]            wt_data,
    input  logic                    px_valid,
    output logic                    px_ready,
    input  logic [W-1:0]            px_data,
    output logic                    pe_we,
    output logic [W-1:0]            pe_weight_in,
    output logic                    pe_start,
    output logic [W-1:0]            pe_indata,
    output logic                    res_valid,
    output logic [$clog2(DIM)-1:0]  res_row,
    output logic [$clog2(DIM)-1:0]  res_col,
    output logic                    busy,
    output logic                    done
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int NUM_W = K * K;
    localparam int NPX   = DIM * DIM;
    localparam int RCW   = $clog2(DIM);
    localparam int WCW_L = $clog2(NUM_W + 1);
    localparam int PCW_L = $clog2(NPX + 1);
    localparam int GCW   = $clog2(GAP + 1);
    localparam int LCW   = $clog2(PE_LAT + 1);
    localparam int DLW   = 1 + 2 * RCW;

    seq_state_e       state_r, state_n_s;
    logic             wt_ready_r, px_ready_r, busy_r, done_r;
    logic             pe_we_r, pe_start_r;
    logic [W-1:0]     pe_weight_in_r, pe_indata_r;
    logic [WCW_L-1:0] wt_cnt_r;
    logic [PCW_L-1:0] px_cnt_r;
    logic [GCW-1:0]   gap_cnt_r;
    logic [LCW-1:0]   drain_cnt_r;
    logic [RCW-1:0]   row_r, col_r;
    logic             wt_acc_s, px_acc_s, win_s;
    logic [DLW-1:0]   dl_in_s, dl_out_s;

    assign wt_acc_s = wt_valid & wt_ready_r;
    assign px_acc_s = px_valid & px_ready_r;

    // Next-state decode
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_n_s = S_LOAD_W;
                else       state_n_s = S_IDLE;
            end
            S_LOAD_W: begin
                if (wt_acc_s && (wt_cnt_r == WCW_L'(NUM_W - 1))) state_n_s = S_GAP;
                else                                            state_n_s = S_LOAD_W;
            end
            S_GAP: begin
                if (gap_cnt_r == GCW'(GAP - 1)) state_n_s = S_STREAM;
                else                            state_n_s = S_GAP;
            end
            S_STREAM: begin
                if (px_acc_s && (px_cnt_r == PCW_L'(NPX - 1))) state_n_s = S_DRAIN;
                else                                           state_n_s = S_STREAM;
            end
            S_DRAIN: begin
                if (drain_cnt_r == LCW'(PE_LAT - 1)) state_n_s = S_DONE;
                else                                 state_n_s = S_DRAIN;
            end
            S_DONE:  state_n_s = S_IDLE;
            default: state_n_s = S_IDLE;
        endcase
    end

    // State register; handshake/status outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            wt_ready_r <= 1'b0;
            px_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            wt_ready_r <= (state_n_s == S_LOAD_W);
            px_ready_r <= (state_n_s == S_STREAM);
            busy_r     <= (state_n_s != S_IDLE);
            done_r     <= (state_n_s == S_DONE);
        end
    end

    // Job counters; IDLE parks them all at zero for the next job
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wt_cnt_r    <= '0;
            px_cnt_r    <= '0;
            gap_cnt_r   <= '0;
            drain_cnt_r <= '0;
            row_r       <= '0;
            col_r       <= '0;
        end else if (state_r == S_IDLE) begin
            wt_cnt_r    <= '0;
            px_cnt_r    <= '0;
            gap_cnt_r   <= '0;
            drain_cnt_r <= '0;
            row_r       <= '0;
            col_r       <= '0;
        end else begin
            if (wt_acc_s) wt_cnt_r <= wt_cnt_r + WCW_L'(1);
            if (state_r == S_GAP) gap_cnt_r <= gap_cnt_r + GCW'(1);
            if (state_r == S_DRAIN) drain_cnt_r <= drain_cnt_r + LCW'(1);
            if (px_acc_s) begin
                px_cnt_r <= px_cnt_r + PCW_L'(1);
                if (col_r == RCW'(DIM - 1)) begin
                    col_r <= '0;
                    row_r <= row_r + RCW'(1);
                end else begin
                    col_r <= col_r + RCW'(1);
                end
            end
        end
    end

    // PE pin registers: one-cycle latency from acceptance, data held across bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_we_r        <= 1'b0;
            pe_start_r     <= 1'b0;
            pe_weight_in_r <= '0;
            pe_indata_r    <= '0;
        end else begin
            pe_we_r    <= wt_acc_s;
            pe_start_r <= px_acc_s;
            if (wt_acc_s) pe_weight_in_r <= wt_data;
            if (px_acc_s) pe_indata_r    <= px_data;
        end
    end

    // A pixel completing a full KxK window tags the output coordinate of that window
    assign win_s   = px_acc_s && (row_r >= RCW'(K - 1)) && (col_r >= RCW'(K - 1));
    assign dl_in_s = win_s ? {1'b1, row_r - RCW'(K - 1), col_r - RCW'(K - 1)} : '0;

    pe_seq_delay #(
        .DEPTH (1 + PE_LAT),
        .WIDTH (DLW)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst),
        .din   (dl_in_s),
        .dout  (dl_out_s)
    );

    assign res_valid    = dl_out_s[DLW-1];
    assign res_row      = dl_out_s[2*RCW-1:RCW];
    assign res_col      = dl_out_s[RCW-1:0];
    assign wt_ready     = wt_ready_r;
    assign px_ready     = px_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pe_we        = pe_we_r;
    assign pe_start     = pe_start_r;
    assign pe_weight_in = pe_weight_in_r;
    assign pe_indata    = pe_indata_r;

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of STREAM bubbles, cleared by an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == S_IDLE) && start) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == S_STREAM) && !px_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule
